// File: rtl/pwm_pkg.sv
// pwm_pkg: state encoding and counter width shared by the PWM generator and capture blocks
package pwm_pkg;
    localparam int PWM_WIDTH = 17;
    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEAS_HIGH, MEAS_LOW} pwm_state_t;
endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control input, measured pin and measurement results of the capture block
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
);
    logic             enable;
    logic             sigin;
    logic [WIDTH-1:0] ontime;
    logic [WIDTH-1:0] offtime;
    logic             valid;
    logic             overflow;
    logic             stuck;
    modport master (output enable, sigin, input ontime, offtime, valid, overflow, stuck);
    modport slave (input enable, sigin, output ontime, offtime, valid, overflow, stuck);
endinterface

// File: rtl/pwm_capture_sync_edge.sv
// sync_edge: synchronise an asynchronous pin and flag its rising and falling edges
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clkin,
    input  logic rst,
    input  logic i_sig,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    // synchroniser chain plus a one-cycle-delayed copy of its output for edge detection
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_s_d  <= r_sync[SYNC_STAGES-1];
        end
    end
    assign o_s    = r_sync[SYNC_STAGES-1];
    assign o_rise = o_s & ~r_s_d;
    assign o_fall = ~o_s & r_s_d;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high/low time of an external pin, one result pair per rise-to-rise period
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input logic          clkin,
    input logic          rst,
    pwm_capture_if.slave bus
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    pwm_state_t       r_state, w_next;
    logic [WIDTH-1:0] r_cnt, r_hi_len, r_ontime, r_offtime;
    logic             r_hi_sat, r_valid, r_overflow;
    logic             w_unused_s, w_rise, w_fall, w_sat, w_cap_hi, w_report;
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clkin  (clkin),
        .rst    (rst),
        .i_sig  (bus.sigin),
        .o_s    (w_unused_s),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );
    assign w_sat    = r_cnt == CNT_MAX;
    assign w_cap_hi = bus.enable && r_state == MEAS_HIGH && w_fall;
    assign w_report = bus.enable && r_state == MEAS_LOW && w_rise;
    // state register
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // next state: a full period must start on a rise, so WAIT_EDGE discards partial levels
    always_comb begin
        w_next = r_state;
        if (!bus.enable) w_next = IDLE;
        else begin
            case (r_state)
                IDLE:      w_next = WAIT_EDGE;
                WAIT_EDGE: w_next = w_rise ? MEAS_HIGH : WAIT_EDGE;
                MEAS_HIGH: w_next = w_fall ? MEAS_LOW : MEAS_HIGH;
                MEAS_LOW:  w_next = w_rise ? MEAS_HIGH : MEAS_LOW;
                default:   w_next = IDLE;
            endcase
        end
    end
    // phase counter: restarts at 1 on every edge so its pre-reload value is the level length
    always_ff @(posedge clkin or posedge rst) begin
        if (rst)                                r_cnt <= '0;
        else if (r_state == IDLE || !bus.enable) r_cnt <= '0;
        else if (w_rise || w_fall)              r_cnt <= WIDTH'(1);
        else if (!w_sat)                        r_cnt <= r_cnt + 1'b1;
    end
    // high-time capture on the fall, result publication and strobe on the closing rise
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_hi_len   <= '0;
            r_hi_sat   <= 1'b0;
            r_ontime   <= '0;
            r_offtime  <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= w_report;
            if (w_cap_hi) begin
                r_hi_len <= r_cnt;
                r_hi_sat <= w_sat;
            end
            if (w_report) begin
                r_ontime   <= r_hi_len;
                r_offtime  <= r_cnt;
                r_overflow <= r_hi_sat | w_sat;
            end
        end
    end
    assign bus.ontime   = r_ontime;
    assign bus.offtime  = r_offtime;
    assign bus.valid    = r_valid;
    assign bus.overflow = r_overflow;
    assign bus.stuck    = w_sat && (r_state == MEAS_HIGH || r_state == MEAS_LOW);
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed waveform sequences with hand-computed on/off times, 8-bit counters
module tb_pwm_capture;
    logic       clk;
    logic       rst;
    int         ntot  = 0;
    int         npass = 0;
    int         nfail = 0;
    int         cyc   = 0;
    int         nv    = 0;
    int         vcyc  = -1;
    int         ival  = 0;
    int         r;
    logic [7:0] q_on[$];
    logic [7:0] q_off[$];

    pwm_capture_if #(.WIDTH(8)) bus();

    pwm_capture #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clkin (clk),
        .rst   (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.valid === 1'b1) begin
            nv++;
            if (vcyc >= 0) ival = cyc - vcyc;
            vcyc = cyc;
            q_on.push_back(bus.ontime);
            q_off.push_back(bus.offtime);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        bus.sigin = lvl;
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.enable = 1'b1;
        bus.sigin  = 1'b0;
        repeat (3) tick();
        check("rst_ontime", bus.ontime, 0);
        check("rst_offtime", bus.offtime, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_stuck", bus.stuck, 0);
        rst = 1'b0;
        hold(0, 5);
        // 4 high / 6 low: first rise only opens the period
        nv = 0;
        hold(1, 4);
        hold(0, 6);
        check("t1_no_partial", nv, 0);
        r = cyc;
        hold(1, 4);
        check("t1_latency", vcyc - r, 3);
        check("t1_on", bus.ontime, 4);
        check("t1_off", bus.offtime, 6);
        check("t1_ovf", bus.overflow, 0);
        hold(0, 6);
        hold(1, 4);
        hold(0, 6);
        hold(1, 4);
        check("t1_count", nv, 3);
        check("t1_interval", ival, 10);
        // 1 high / 1 low toggling
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            hold(0, 1);
            hold(1, 1);
        end
        check("t2_count", nv, 9);
        check("t2_on", bus.ontime, 1);
        check("t2_off", bus.offtime, 1);
        check("t2_interval", ival, 2);
        // period change 8/8 -> 3/2 at a rising edge
        q_on.delete();
        q_off.delete();
        hold(0, 8);
        hold(1, 8);
        hold(0, 8);
        hold(1, 8);
        hold(0, 8);
        hold(1, 3);
        hold(0, 2);
        hold(1, 3);
        hold(0, 4);
        check("t6_count", q_on.size(), 5);
        if (q_on.size() == 5) begin
            check("t6_on_old", q_on[3], 8);
            check("t6_off_old", q_off[3], 8);
            check("t6_on_new", q_on[4], 3);
            check("t6_off_new", q_off[4], 2);
        end
        // held high beyond 255 cycles saturates the counter
        hold(1, 256);
        check("t3_stuck_pre", bus.stuck, 0);
        hold(1, 1);
        check("t3_stuck_set", bus.stuck, 1);
        hold(1, 43);
        check("t3_stuck_hold", bus.stuck, 1);
        hold(0, 10);
        check("t3_stuck_clr", bus.stuck, 0);
        hold(1, 4);
        check("t3_on_sat", bus.ontime, 255);
        check("t3_off", bus.offtime, 10);
        check("t3_ovf_set", bus.overflow, 1);
        hold(0, 6);
        hold(1, 4);
        check("t3_on_next", bus.ontime, 4);
        check("t3_ovf_clr", bus.overflow, 0);
        // steady 10/10 with enable dropped mid-high
        hold(0, 10);
        hold(1, 10);
        hold(0, 10);
        hold(1, 3);
        check("t4_on", bus.ontime, 10);
        check("t4_off", bus.offtime, 10);
        nv = 0;
        bus.enable = 1'b0;
        hold(1, 5);
        check("t4_dis_valid", bus.valid, 0);
        check("t4_dis_stuck", bus.stuck, 0);
        bus.enable = 1'b1;
        hold(1, 2);
        hold(0, 10);
        hold(1, 10);
        hold(0, 10);
        check("t4_no_valid", nv, 0);
        check("t4_hold_on", bus.ontime, 10);
        check("t4_hold_off", bus.offtime, 10);
        hold(1, 10);
        check("t4_resume", nv, 1);
        // asynchronous reset in MEAS_LOW
        hold(0, 5);
        #3;
        rst = 1'b1;
        #1;
        check("t5_rst_on", bus.ontime, 0);
        check("t5_rst_off", bus.offtime, 0);
        check("t5_rst_valid", bus.valid, 0);
        check("t5_rst_stuck", bus.stuck, 0);
        #2;
        rst = 1'b0;
        nv = 0;
        hold(0, 5);
        hold(1, 10);
        hold(0, 10);
        check("t5_no_valid", nv, 0);
        hold(1, 10);
        check("t5_count", nv, 1);
        check("t5_on", bus.ontime, 10);
        check("t5_off", bus.offtime, 10);
        check("t5_ovf", bus.overflow, 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures the high time and low time of an external digital signal, in clkin cycles. It is the receive-side counterpart of the team's PWM generator and serves the frequency/duty-cycle measurement mode on a Bus Pirate I/O pin. Each completed period (rising edge to rising edge) produces one ontime/offtime pair with a one-cycle valid strobe. Counters saturate and flag overflow and stuck-level conditions.

Parameters:
WIDTH, 17, width of the counters and the ontime/offtime outputs (matches the generator's period width).
SYNC_STAGES, 2, number of flip-flops in the sigin synchroniser (minimum 2).

Ports:
clkin     input   1      system clock
rst       input   1      asynchronous, active-high reset
enable    input   1      measurement enable; low forces IDLE
sigin     input   1      asynchronous signal under measurement
ontime    output  WIDTH  high duration of the last complete period, in clkin cycles
offtime   output  WIDTH  low duration of the last complete period, in clkin cycles
valid     output  1      one-cycle strobe; ontime/offtime updated this cycle
overflow  output  1      the last reported pair contained a saturated value
stuck     output  1      the current phase counter is saturated (level held too long)

Behaviour:
- Reset: ontime=0, offtime=0, valid=0, overflow=0, stuck=0, state=IDLE, synchroniser flops=0, counters=0.
- sigin passes through SYNC_STAGES flops to give s. A registered copy of s gives s_d. Rise = s & ~s_d. Fall = ~s & s_d.
- Phase counter cnt: set to 1 on any edge cycle; otherwise it increments and saturates at 2^WIDTH-1. The value held on the edge cycle, before reload, is the length of the previous level. A level lasting N cycles measures N.
- hi_len register: captures cnt on a fall while in MEAS_HIGH. hi_sat: set if that captured value was saturated.
- States:
  - IDLE: entered when enable=0; cnt cleared. When enable=1, go to WAIT_EDGE.
  - WAIT_EDGE: cnt is don't-care. On rise, go to MEAS_HIGH (cnt=1). Partial periods are never reported.
  - MEAS_HIGH: on fall, capture hi_len and go to MEAS_LOW.
  - MEAS_LOW: on rise, ontime<=hi_len, offtime<=cnt, overflow<=hi_sat | (cnt saturated), valid=1 for one cycle, then go to MEAS_HIGH (cnt=1).
- enable low in any state goes to IDLE on the next edge of clkin. valid stays 0, ontime/offtime/overflow hold their last values, and stuck clears.
- stuck=1 while in MEAS_HIGH or MEAS_LOW and cnt==2^WIDTH-1. It clears on the next edge.
- Latency: valid asserts on the same clock as the registered rise detection, i.e. SYNC_STAGES+1 clkin edges after sigin rises (sigin meeting setup). Outputs hold until the next valid.
- A rise and a fall cannot occur on the same cycle (a single bit). Pulses shorter than one clkin period may be missed; this is not an error.
- rst asserted mid-measurement clears everything immediately. After release, the block behaves as freshly enabled: a full period is needed before the first valid.

Decomposition:
- Shared package pwm_pkg: state enum (IDLE, WAIT_EDGE, MEAS_HIGH, MEAS_LOW) and PWM_WIDTH=17 constant, shared with the generator.
- Sub-module sync_edge: SYNC_STAGES synchroniser plus s_d register; outputs s, rise, fall. Reusable by other pin-input blocks.

Test Plan:
- Generator-driven waveform, onperiod=3, offperiod=5, enable=1 → first valid follows the second sigin rise; ontime=4, offtime=6, overflow=0; valid repeats every 10 cycles.
- sigin toggles every clkin cycle (1 high / 1 low) → ontime=1, offtime=1, valid every 2 cycles after startup.
- WIDTH=17, sigin held high for 140000 cycles, then low for 10, then rising → stuck=1 from high-count 131071 until the fall; reported ontime=131071, offtime=10, overflow=1. The next normal period reports overflow=0.
- Steady period 10/10, enable dropped mid-high for 5 cycles then restored → no valid while disabled or during the first partial period; outputs hold 10/10; next valid only after a fresh full rise-to-rise.
- rst pulsed asynchronously mid-MEAS_LOW → ontime=offtime=0, valid=0, stuck=0 immediately; first valid after release reports the correct full period.
- Period change from 8/8 to 3/2 at a rising edge → next valid reports 3/2 with no intermediate mixed value.
